debounce_filter_multi: RTL and testbench
========================================

Name: debounce_filter_multi

Overview:
- Parametrised, multi-channel successor to the single-input debounce filter. It filters NUM_CHANNELS independent bouncy inputs, such as switches and buttons.
- Each channel first passes through a configurable synchroniser, then through its own stability counter.
- Each channel produces a debounced level plus one-cycle rising-edge and falling-edge pulses. This removes the need for separate edge detectors downstream.
- Sits between the board-level input pins and the user logic, such as an LED or state-machine control.

Parameters:
- NUM_CHANNELS, 4, number of independent input channels (1..32).
- DEBOUNCE_LIMIT, 250000, consecutive clock cycles a synchronised input must differ from the current debounced state before that state flips (>=1).
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (0..3). A value of 0 means the input is used directly.
- INIT_LEVEL, 0, value of every synchroniser flop and every debounced output during and after reset (0 or 1).

Ports:
- i_Clk  input  1  system clock. This is the only clock.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Bouncy  input  NUM_CHANNELS  raw, possibly asynchronous, inputs, one bit per channel.
- o_Debounced  output  NUM_CHANNELS  filtered level per channel.
- o_Rise  output  NUM_CHANNELS  one-cycle pulse when a channel's debounced level goes 0->1.
- o_Fall  output  NUM_CHANNELS  one-cycle pulse when a channel's debounced level goes 1->0.
- o_Any_Change  output  1  registered OR of all o_Rise and o_Fall bits. Asserts in the same cycle as those pulses.

Behaviour:
- Reset:
  - i_Rst_L low clears all state asynchronously, with no clock required.
  - Synchroniser flops and o_Debounced take INIT_LEVEL on all bits.
  - Counters are set to 0.
  - o_Rise, o_Fall and o_Any_Change are 0.
  - Reset release is synchronous in effect: the first active edge is the first rising i_Clk edge with i_Rst_L high.
- Synchroniser:
  - Each channel has its own SYNC_STAGES-deep shift chain clocked by i_Clk.
  - s[n] is the last stage's output, or i_Bouncy[n] directly when SYNC_STAGES=0.
- Per-channel counter:
  - Width is max(1, clog2(DEBOUNCE_LIMIT)) bits.
  - Evaluated on every rising edge, in this order:
    - s[n] == o_Debounced[n]: count <= 0.
    - s[n] != o_Debounced[n] and count < DEBOUNCE_LIMIT-1: count <= count+1.
    - s[n] != o_Debounced[n] and count == DEBOUNCE_LIMIT-1: o_Debounced[n] <= s[n] and count <= 0.
  - Consequence: exactly DEBOUNCE_LIMIT consecutive differing samples are required. Any single matching sample (a glitch back to the old level) restarts the count from 0.
  - The counter never wraps and never exceeds DEBOUNCE_LIMIT-1.
  - With DEBOUNCE_LIMIT=1, the output follows s[n] with one cycle of delay.
- Latency:
  - Call the first edge that samples a new, stable i_Bouncy value edge 1.
  - o_Debounced updates on edge SYNC_STAGES+DEBOUNCE_LIMIT.
  - o_Rise or o_Fall is high for exactly the cycle following that edge.
- Edge pulses:
  - o_Rise[n] and o_Fall[n] are registered and asserted on the same edge that flips o_Debounced[n].
  - They deassert on the next edge. They are never both high for one channel.
  - A channel cannot pulse in two consecutive cycles unless DEBOUNCE_LIMIT=1.
- Channel independence:
  - Channels share no state.
  - Simultaneous flips on several channels give simultaneous pulses on all of them, with one o_Any_Change cycle.
- Reset mid-count:
  - Partial counts are discarded and no pulse is generated.
  - After release, an input already at !INIT_LEVEL needs the full SYNC_STAGES+DEBOUNCE_LIMIT edges to register.
  - That flip does produce a pulse.
- No combinational path from i_Bouncy to any output; all outputs come directly from flops.

Test Plan:
Setup for all tests: NUM_CHANNELS=4, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, INIT_LEVEL=0, 4-time-unit clock. Edge 1 is the first edge that samples the stimulus.
- Reset values: hold i_Rst_L low for 3 cycles with i_Bouncy=4'hF -> o_Debounced=4'h0, o_Rise=o_Fall=0 and o_Any_Change=0 throughout. Then release -> o_Debounced=4'hF on edge 6, o_Rise=4'hF and o_Any_Change=1 for exactly 1 cycle.
- Clean rise: i_Bouncy[0] 0->1 and held -> o_Debounced[0]=1 on edge 6, o_Rise[0]=1 for 1 cycle, other bits unchanged.
- Glitch rejection: i_Bouncy[1] sequence 1,0,1 held -> count restarts after the 0. o_Debounced[1]=1 on edge 8 (edge 3 + 2 + 4 - 1), single o_Rise[1] pulse.
- Short pulse rejection: i_Bouncy[2]=1 for 3 cycles, then 0 -> o_Debounced[2] stays 0 and no o_Rise/o_Fall pulses for 20 cycles.
- Fall and simultaneous flips: from o_Debounced=4'hF, i_Bouncy -> 4'h5 -> o_Fall=4'hA for 1 cycle on edge 6, o_Debounced=4'h5, o_Rise=0, single o_Any_Change cycle.
- Reset mid-count: i_Bouncy[3]=1, assert i_Rst_L low after edge 4 for 2 cycles -> no pulse during the count or the reset. After release, o_Debounced[3]=1 exactly 6 edges later, with one o_Rise[3] pulse.

Source files
------------

// File: rtl/debounce_filter_multi.sv
// Multi-channel debounce filter.
// Each channel has its own optional synchroniser, followed by a stability counter.
// Each channel produces a registered debounced level plus one-cycle rise and fall pulses.
// o_Any_Change is a single flop that fires in the same cycle as any channel's pulse.

// ---------------------------------------------------------------------------
// Per-channel filter: synchroniser chain, stability counter, level, edge pulses.
// o_Rise_Nxt / o_Fall_Nxt expose the pulse next-state so the top level can
// register the aggregated change flag in lockstep with the per-channel pulses.
// ---------------------------------------------------------------------------
module debounce_filter_chan #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2,
  parameter int INIT_LEVEL     = 0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Bouncy,
  output logic o_Debounced,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Rise_Nxt,
  output logic o_Fall_Nxt
);

  localparam int              CNT_W   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic            INIT_B  = (INIT_LEVEL != 0);

  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             deb_q, deb_nxt;
  logic             rise_q, fall_q;
  logic             rise_nxt, fall_nxt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      // Caller guarantees the input is already in the i_Clk domain.
      assign s = i_Bouncy;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift chain: stage 0 captures the raw pin, and the last stage feeds the counter.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          sync_q <= {SYNC_STAGES{INIT_B}};
        end else begin
          sync_q[0] <= i_Bouncy;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Stability counter: any sample matching the current level restarts the count.
  // The level flips only after DEBOUNCE_LIMIT consecutive differing samples.
  always_comb begin
    cnt_nxt  = cnt_q;
    deb_nxt  = deb_q;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (s == deb_q) begin
      cnt_nxt = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_nxt  = '0;
      deb_nxt  = s;
      rise_nxt = s;
      fall_nxt = ~s;
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  // Level, count and edge pulses all update on the same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q  <= '0;
      deb_q  <= INIT_B;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      deb_q  <= deb_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
    end
  end

  assign o_Debounced = deb_q;
  assign o_Rise      = rise_q;
  assign o_Fall      = fall_q;
  assign o_Rise_Nxt  = rise_nxt;
  assign o_Fall_Nxt  = fall_nxt;

endmodule

// ---------------------------------------------------------------------------
// Top level: an array of independent channels plus the aggregated change flag.
// ---------------------------------------------------------------------------
module debounce_filter_multi #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2,
  parameter int INIT_LEVEL     = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_CHANNELS-1:0] i_Bouncy,
  output logic [NUM_CHANNELS-1:0] o_Debounced,
  output logic [NUM_CHANNELS-1:0] o_Rise,
  output logic [NUM_CHANNELS-1:0] o_Fall,
  output logic                    o_Any_Change
);

  logic [NUM_CHANNELS-1:0] rise_nxt;
  logic [NUM_CHANNELS-1:0] fall_nxt;
  logic                    any_q;

  generate
    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_chan
      debounce_filter_chan #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
        .SYNC_STAGES    (SYNC_STAGES),
        .INIT_LEVEL     (INIT_LEVEL)
      ) u_chan (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Bouncy    (i_Bouncy[n]),
        .o_Debounced (o_Debounced[n]),
        .o_Rise      (o_Rise[n]),
        .o_Fall      (o_Fall[n]),
        .o_Rise_Nxt  (rise_nxt[n]),
        .o_Fall_Nxt  (fall_nxt[n])
      );
    end
  endgenerate

  // Registering the OR of the pulse next-states lines the flag up with the pulses.
  // This avoids a combinational OR on the output.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) any_q <= 1'b0;
    else          any_q <= |(rise_nxt | fall_nxt);
  end

  assign o_Any_Change = any_q;

endmodule

// File: tb/tb_debounce_filter_multi.sv
// Directed bench for debounce_filter_multi.
// Configuration: 4 channels, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, 4-unit clock.
// Inputs are driven 1 unit after a rising edge, and outputs are sampled at the same point.
module tb_debounce_filter_multi;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] bouncy;
  logic [3:0] deb, rise, fall;
  logic       any_chg;

  int vec_cnt = 0;
  int err_cnt = 0;

  debounce_filter_multi #(
    .NUM_CHANNELS   (4),
    .DEBOUNCE_LIMIT (4),
    .SYNC_STAGES    (2),
    .INIT_LEVEL     (0)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Bouncy     (bouncy),
    .o_Debounced  (deb),
    .o_Rise       (rise),
    .o_Fall       (fall),
    .o_Any_Change (any_chg)
  );

  always #2 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ed, input logic [3:0] er,
                         input logic [3:0] ef, input logic ea);
    chk({tag, " deb"},  32'(deb),     32'(ed));
    chk({tag, " rise"}, 32'(rise),    32'(er));
    chk({tag, " fall"}, 32'(fall),    32'(ef));
    chk({tag, " any"},  32'(any_chg), 32'(ea));
  endtask

  // Walks edges from..to. The level switches d0->d1 at edge 'flip', and the masks pulse only on that edge.
  // A flip of -1 means no change is expected at all.
  task automatic run(input string tag, input int from, input int to, input int flip,
                     input logic [3:0] d0, input logic [3:0] d1,
                     input logic [3:0] rm, input logic [3:0] fm);
    for (int e = from; e <= to; e++) begin
      @(posedge clk); #1;
      chk_all($sformatf("%s e%0d", tag, e),
              (flip > 0 && e >= flip) ? d1 : d0,
              (e == flip) ? rm : 4'h0,
              (e == flip) ? fm : 4'h0,
              (e == flip) && ((rm | fm) != 4'h0));
    end
  endtask

  // Asserts reset with no clock, checks the asynchronous clear, then holds for n edges.
  // Called and returns at a point 1 unit after an edge.
  task automatic do_reset(input string tag, input int n);
    rst_l = 1'b0;
    #1;
    chk_all({tag, " async"}, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("%s hold%0d", tag, i), 4'h0, 4'h0, 4'h0, 1'b0);
    end
    rst_l = 1'b1;
  endtask

  initial begin
    rst_l  = 1'b1;
    bouncy = 4'hF;
    @(posedge clk); #1;

    // Reset with all inputs high, then release: all four channels rise on edge 6.
    do_reset("rst", 3);
    run("rst_rel", 1, 8, 6, 4'h0, 4'hF, 4'hF, 4'h0);

    // Clean rise on channel 0 from an all-zero state.
    bouncy = 4'h0;
    do_reset("rst0", 1);
    run("settle0", 1, 4, -1, 4'h0, 4'h0, 4'h0, 4'h0);
    bouncy = 4'h1;
    run("rise0", 1, 8, 6, 4'h0, 4'h1, 4'h1, 4'h0);

    // Glitch on channel 1: the input goes 1, 0, then stays 1. Edge 2's zero restarts the count.
    bouncy = 4'h3;
    run("glitch", 1, 1, -1, 4'h1, 4'h1, 4'h0, 4'h0);
    bouncy = 4'h1;
    run("glitch", 2, 2, -1, 4'h1, 4'h1, 4'h0, 4'h0);
    bouncy = 4'h3;
    run("glitch", 3, 12, 8, 4'h1, 4'h3, 4'h2, 4'h0);

    // A 3-cycle pulse on channel 2 is one sample short and must be ignored.
    bouncy = 4'h7;
    run("short", 1, 3, -1, 4'h3, 4'h3, 4'h0, 4'h0);
    bouncy = 4'h3;
    run("short", 4, 23, -1, 4'h3, 4'h3, 4'h0, 4'h0);

    // Bring all channels high, then drop channels 1 and 3 together.
    bouncy = 4'hF;
    run("toF", 1, 8, 6, 4'h3, 4'hF, 4'hC, 4'h0);
    bouncy = 4'h5;
    run("fall", 1, 8, 6, 4'hF, 4'h5, 4'h0, 4'hA);

    // Reset mid-count on channel 3: the partial count is lost, and the full latency applies after release.
    bouncy = 4'h0;
    do_reset("rst3", 1);
    run("settle3", 1, 4, -1, 4'h0, 4'h0, 4'h0, 4'h0);
    bouncy = 4'h8;
    run("mid", 1, 4, -1, 4'h0, 4'h0, 4'h0, 4'h0);
    do_reset("mid_rst", 2);
    run("mid_rel", 1, 10, 6, 4'h0, 4'h8, 4'h8, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
